// File: rtl/bin_to_onehot_scan.sv
// bin_to_onehot_scan: registered N-to-2^N one-hot select with an active-low
// enable, direct decode, up/down auto-scan with programmable dwell, and hold.
// idx, Y, step and wrap all update on the same edge, so downstream logic sees
// the select change and its pulses together.
module bin_to_onehot_scan #(
  parameter int N              = 4,
  parameter int DWELL          = 4,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                E,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        X,
  input  logic                in_valid,
  output logic [(1<<N)-1:0]   Y,
  output logic [N-1:0]        idx,
  output logic                step,
  output logic                wrap
);

  localparam int             W         = 1 << N;
  localparam int             DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]  DCNT_LAST = DW'(DWELL - 1);
  // XOR mask: all-inactive pattern, also used to invert the one-hot word.
  localparam logic [W-1:0]   Y_IDLE    = {W{OUT_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  mode_e          mode_cur;
  mode_e          mode_q;
  logic [DW-1:0]  dcnt;
  logic [DW-1:0]  dcnt_next;
  logic [N-1:0]   idx_next;
  logic           wrap_next;
  logic [W-1:0]   y_next;

  assign mode_cur = mode_e'(mode);

  // Next index, dwell count and wrap flag; priority is enable, then mode change, then mode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    idx_next  = idx;
    dcnt_next = '0;
    wrap_next = 1'b0;
    if (!E && (mode_cur == mode_q)) begin
      unique case (mode_cur)
        MODE_DECODE: begin
          if (in_valid) idx_next = X;
        end
        MODE_SCAN_UP: begin
          if (dcnt == DCNT_LAST) begin
            idx_next  = idx + N'(1);
            wrap_next = &idx;
          end else begin
            dcnt_next = dcnt + DW'(1);
          end
        end
        MODE_SCAN_DOWN: begin
          if (dcnt == DCNT_LAST) begin
            idx_next  = idx - N'(1);
            wrap_next = ~|idx;
          end else begin
            dcnt_next = dcnt + DW'(1);
          end
        end
        MODE_HOLD: begin
          dcnt_next = dcnt;
        end
        default: ;
      endcase
    end
    // A mode change (or E=1) falls through with idx held and dcnt cleared.
  end

  // One-hot of the next index, inverted for active-low outputs.
  always_comb begin
    y_next = (W'(1) << idx_next) ^ Y_IDLE;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
    if (!rst_n) begin
      idx    <= '0;
      dcnt   <= '0;
      mode_q <= MODE_DECODE;
      Y      <= Y_IDLE;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode_cur;
      idx    <= idx_next;
      dcnt   <= dcnt_next;
      Y      <= E ? Y_IDLE : y_next;
      step   <= (idx_next != idx);
      wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_bin_to_onehot_scan.sv
// Directed bench for bin_to_onehot_scan: a decode vector table plus hand-written
// scan, hold, enable and reset sequences on N=4/DWELL=3, and a second instance
// with N=2/DWELL=1/OUT_ACTIVE_LOW=1 for the parameter corner.
module tb_bin_to_onehot_scan;

  logic        clk = 1'b0;
  logic        rst_n, e, in_valid;
  logic [1:0]  mode;
  logic [3:0]  x;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        step, wrap;

  logic        rst_n_b, e_b, in_valid_b;
  logic [1:0]  mode_b;
  logic [1:0]  x_b;
  logic [3:0]  y_b;
  logic [1:0]  idx_b;
  logic        step_b, wrap_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        e;
    logic [1:0]  mode;
    logic        iv;
    logic [3:0]  x;
    logic [15:0] exp_y;
    logic [3:0]  exp_idx;
    logic        exp_step;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  bin_to_onehot_scan #(.N(4), .DWELL(3), .OUT_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .E(e), .mode(mode), .X(x), .in_valid(in_valid),
    .Y(y), .idx(idx), .step(step), .wrap(wrap)
  );

  bin_to_onehot_scan #(.N(2), .DWELL(1), .OUT_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .E(e_b), .mode(mode_b), .X(x_b), .in_valid(in_valid_b),
    .Y(y_b), .idx(idx_b), .step(step_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] ey, input logic [3:0] ei,
                           input logic es, input logic ew);
    check({name, ".Y"},    64'(y),    64'(ey));
    check({name, ".idx"},  64'(idx),  64'(ei));
    check({name, ".step"}, 64'(step), 64'(es));
    check({name, ".wrap"}, 64'(wrap), 64'(ew));
  endtask

  function automatic vec_t mk(input logic ev, input logic [1:0] m, input logic iv, input logic [3:0] xv,
                              input logic [15:0] ey, input logic [3:0] ei, input logic es, input logic ew);
    vec_t v;
    v.e = ev; v.mode = m; v.iv = iv; v.x = xv;
    v.exp_y = ey; v.exp_idx = ei; v.exp_step = es; v.exp_wrap = ew;
    return v;
  endfunction

  initial begin
    logic [3:0] prev;
    logic [1:0] ei_b;
    logic [3:0] ey_b;

    // Decode table, starting from idx=0 with mode 00 already registered.
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'd3, 16'h0008, 4'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'd3, 16'h0008, 4'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'd5, 16'h0020, 4'd5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'd5, 16'h0020, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 4'd9, 16'h0020, 4'd5, 1'b0, 1'b0));
    prev = 4'd5;
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'(i), 16'(32'd1 << i), 4'(i), 1'(4'(i) != prev), 1'b0));
      prev = 4'(i);
    end
    vecs.push_back(mk(1'b1, 2'b00, 1'b1, 4'd7,  16'h0000, 4'd15, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'd7,  16'h0080, 4'd7,  1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 4'd14, 16'h4000, 4'd14, 1'b1, 1'b0));

    rst_n = 1'b0; e = 1'b0; mode = 2'b00; x = 4'd0; in_valid = 1'b0;
    rst_n_b = 1'b0; e_b = 1'b0; mode_b = 2'b00; x_b = 2'd0; in_valid_b = 1'b0;

    // Reset held for two edges.
    tick(); tick();
    check_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    check("reset_b.Y", 64'(y_b), 64'h0F);
    rst_n = 1'b1;
    tick();
    check_out("post_reset", 16'h0001, 4'd0, 1'b0, 1'b0);

    // Table-driven decode, enable and re-enable vectors.
    foreach (vecs[i]) begin
      e = vecs[i].e; mode = vecs[i].mode; in_valid = vecs[i].iv; x = vecs[i].x;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_idx, vecs[i].exp_step, vecs[i].exp_wrap);
    end

    // Scan-up from 14 across the wrap.
    mode = 2'b01; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); check_out("up_14", 16'h4000, 4'd14, 1'b0, 1'b0); end
    tick(); check_out("up_15_step", 16'h8000, 4'd15, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin tick(); check_out("up_15", 16'h8000, 4'd15, 1'b0, 1'b0); end
    tick(); check_out("up_wrap", 16'h0001, 4'd0, 1'b1, 1'b1);
    tick(); check_out("up_after_wrap", 16'h0001, 4'd0, 1'b0, 1'b0);

    // Mode change edge ignores X, next edge decodes it.
    mode = 2'b00; x = 4'd1; in_valid = 1'b1;
    tick(); check_out("chg_to_decode", 16'h0001, 4'd0, 1'b0, 1'b0);
    tick(); check_out("decode_1", 16'h0002, 4'd1, 1'b1, 1'b0);

    // Scan-down from 1 across the wrap, then hold.
    mode = 2'b10; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); check_out("dn_1", 16'h0002, 4'd1, 1'b0, 1'b0); end
    tick(); check_out("dn_0_step", 16'h0001, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin tick(); check_out("dn_0", 16'h0001, 4'd0, 1'b0, 1'b0); end
    tick(); check_out("dn_wrap", 16'h8000, 4'd15, 1'b1, 1'b1);
    tick(); check_out("dn_mid_dwell", 16'h8000, 4'd15, 1'b0, 1'b0);
    mode = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("hold.Y", 64'(y), 64'h8000);
      check("hold.step", 64'(step), 64'h0);
    end

    // Enable pulse during scan-up at idx=7.
    mode = 2'b00; x = 4'd7; in_valid = 1'b1;
    tick(); check_out("chg_from_hold", 16'h8000, 4'd15, 1'b0, 1'b0);
    tick(); check_out("decode_7", 16'h0080, 4'd7, 1'b1, 1'b0);
    mode = 2'b01; in_valid = 1'b0;
    tick(); check_out("up7_entry", 16'h0080, 4'd7, 1'b0, 1'b0);
    tick(); check_out("up7_dwell", 16'h0080, 4'd7, 1'b0, 1'b0);
    e = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); check_out("disabled", 16'h0000, 4'd7, 1'b0, 1'b0); end
    e = 1'b0;
    tick(); check_out("reenable", 16'h0080, 4'd7, 1'b0, 1'b0);
    tick(); check_out("reenable_dwell", 16'h0080, 4'd7, 1'b0, 1'b0);
    tick(); check_out("reenable_step", 16'h0100, 4'd8, 1'b1, 1'b0);

    // Reset in the middle of a scan, then restart from 0.
    tick();
    rst_n = 1'b0;
    tick(); check_out("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); check_out("restart_dwell", 16'h0001, 4'd0, 1'b0, 1'b0); end
    tick(); check_out("restart_step", 16'h0002, 4'd1, 1'b1, 1'b0);

    // N=2, DWELL=1, active-low outputs: one step per edge after the entry edge.
    rst_n_b = 1'b1; mode_b = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      tick();
      ei_b = (k == 1) ? 2'd0 : 2'(k - 1);
      ey_b = ~(4'b0001 << ei_b);
      check($sformatf("b_k%0d.Y", k),    64'(y_b),    64'(ey_b));
      check($sformatf("b_k%0d.step", k), 64'(step_b), 64'(k > 1));
      check($sformatf("b_k%0d.wrap", k), 64'(wrap_b), 64'((k > 1) && (ei_b == 2'd0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
